stream_serializer: RTL and testbench

Single-clock stream serializer that accepts one wide word of `Ratio` narrow lanes over a valid/ready handshake and emits it as `Ratio` consecutive narrow beats over a second valid/ready handshake. It sits in the destination clock domain directly downstream of the isochronous spill register. It consumes that register's wide output and feeds narrow consumers such as byte-wide links or FIFOs. Back-to-back words sustain full output throughput: one narrow beat per cycle with no bubble between words.

---
 rtl/stream_serializer.sv | 147 ++++++++++++++
 tb/tb_stream_serializer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_serializer.sv
// -----------------------------------------------------------------------------
// stream_serializer
//
// Accepts one wide word of Ratio narrow lanes over a valid/ready handshake and
// emits it as Ratio consecutive narrow beats over a second valid/ready
// handshake. Back-to-back words stream with no bubble: the next word is
// accepted in the same cycle the final beat of the current word is taken.
//
// Build option:
//   STREAM_SERIALIZER_MSB_FIRST_EN  defined   -> most-significant lane first
//                                   undefined -> least-significant lane first
//
// Parameters:
//   NarrowWidth  width of one output beat (>= 1)
//   Ratio        beats per input word (>= 2, any integer)
//
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset
//   flush_i  synchronous abort of the word being serialized
//   valid_i  input word valid
//   ready_o  block can accept an input word
//   data_i   input word, lane k at [k*NarrowWidth +: NarrowWidth]
//   valid_o  output beat valid
//   ready_i  downstream accepts the beat
//   data_o   output beat
//   last_o   current beat is the final beat of its word
//   idle_o   no word is held
// -----------------------------------------------------------------------------
module stream_serializer #(
  parameter int unsigned NarrowWidth = 8,
  parameter int unsigned Ratio       = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [NarrowWidth*Ratio-1:0] data_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [NarrowWidth-1:0]       data_o,
  output logic                         last_o,
  output logic                         idle_o
);

  localparam int unsigned CntWidth = ($clog2(Ratio) > 1) ? $clog2(Ratio) : 1;
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(Ratio - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                               state_q, state_d;
  logic [CntWidth-1:0]                  cnt_q, cnt_d;
  logic [Ratio-1:0][NarrowWidth-1:0]    hold_q, hold_d;
  logic [CntWidth-1:0]                  lane_idx;
  logic                                 last_beat;

  always_comb begin
    last_beat = (cnt_q == LastCnt);
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
    lane_idx  = LastCnt - cnt_q;
`else
    lane_idx  = cnt_q;
`endif
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic. The accept condition is written from valid_i/ready_i
  // directly; it matches valid_i && ready_o because flush is handled first.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    if (flush_i) begin
      // Hold register intentionally keeps its contents on flush.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            hold_d  = data_i;
            cnt_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (ready_i) begin
            if (!last_beat) begin
              cnt_d = cnt_q + CntWidth'(1);
            end else if (valid_i) begin
              hold_d = data_i;
              cnt_d  = '0;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output logic. ready_o is combinational from ready_i and flush_i only.
  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    last_o  = 1'b0;
    idle_o  = 1'b0;
    data_o  = '0;
    unique case (state_q)
      IDLE: begin
        ready_o = !flush_i;
        idle_o  = 1'b1;
      end
      SEND: begin
        valid_o = 1'b1;
        last_o  = last_beat;
        data_o  = hold_q[lane_idx];
        ready_o = !flush_i && last_beat && ready_i;
      end
      default: begin
        idle_o = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_stream_serializer.sv
module tb_stream_serializer;

  localparam int unsigned NW = 8;
  localparam int unsigned R  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush_i, valid_i, ready_i;
  logic [NW*R-1:0] data_i;
  logic          ready_o, valid_o, last_o, idle_o;
  logic [NW-1:0] data_o;

  logic          b_valid_i, b_ready_i;
  logic [11:0]   b_data_i;
  logic          b_ready_o, b_valid_o, b_last_o, b_idle_o;
  logic [3:0]    b_data_o;

  always #5 clk = ~clk;

  stream_serializer #(.NarrowWidth(NW), .Ratio(R)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .last_o(last_o), .idle_o(idle_o)
  );

  stream_serializer #(.NarrowWidth(4), .Ratio(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0),
    .valid_i(b_valid_i), .ready_o(b_ready_o), .data_i(b_data_i),
    .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o),
    .last_o(b_last_o), .idle_o(b_idle_o)
  );

  typedef struct {
    logic [NW-1:0] data;
    logic          last;
  } beat_t;

  beat_t q[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    n_acc = 0;

  function automatic logic [NW-1:0] lane_of(logic [NW*R-1:0] w, int i);
    int idx;
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
    idx = R - 1 - i;
`else
    idx = i;
`endif
    return w[idx*NW +: NW];
  endfunction

  function automatic logic [3:0] lane_b(logic [11:0] w, int i);
    int idx;
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
    idx = 2 - i;
`else
    idx = i;
`endif
    return w[idx*4 +: 4];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // One clock cycle: check outputs against the queue model mid-cycle, then
  // advance the model on the rising edge using the currently driven inputs.
  task automatic step();
    logic ev, el, er;
    @(negedge clk);
    ev = (q.size() != 0);
    el = ev && q[0].last;
    er = !flush_i && (!ev || (el && ready_i));
    chk("valid_o", valid_o, ev);
    chk("idle_o", idle_o, !ev);
    chk("ready_o", ready_o, er);
    chk("last_o", last_o, el);
    if (ev) chk("data_o", data_o, q[0].data);
    @(posedge clk);
    if (flush_i) begin
      q.delete();
    end else begin
      if (ev && ready_i) void'(q.pop_front());
      if (er && valid_i) begin
        for (int i = 0; i < R; i++) q.push_back('{lane_of(data_i, i), i == R - 1});
        n_acc++;
      end
    end
    #1;
  endtask

  initial begin
    logic [NW*R-1:0] w;
    int acc0;

    rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
    b_valid_i = 1'b0; b_ready_i = 1'b0; b_data_i = '0;
    #1;
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_last", last_o, 1'b0);
    chk("rst_idle", idle_o, 1'b1);
    chk("rst_data", data_o, 8'h00);
    chk("rst_b_valid", b_valid_o, 1'b0);
    #20; rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word
    w = 32'hDDCCBBAA;
    valid_i = 1'b1; data_i = w; ready_i = 1'b1;
    step();
    valid_i = 1'b0;
    for (int i = 0; i < R; i++) begin
      chk("sw_data", data_o, lane_of(w, i));
      chk("sw_last", last_o, i == R - 1);
      step();
    end
    chk("sw_idle", idle_o, 1'b1);

    // Back-to-back: three words, valid_i and ready_i held high
    acc0 = n_acc;
    for (int c = 0; c < 3 * R + 2; c++) begin
      valid_i = (n_acc - acc0) < 3;
      data_i  = $urandom;
      step();
    end
    chk("b2b_accepts", n_acc - acc0, 3);
    valid_i = 1'b0;

    // Flush on beat 1; simultaneous valid_i must be refused
    w = 32'h44332211;
    valid_i = 1'b1; data_i = w; ready_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("fl_beat0", data_o, lane_of(w, 0));
    step();
    flush_i = 1'b1; valid_i = 1'b1; data_i = 32'hDEADBEEF;
    step();
    flush_i = 1'b0; valid_i = 1'b0;
    chk("fl_valid", valid_o, 1'b0);
    chk("fl_idle", idle_o, 1'b1);
    step();
    step();

    // Ratio = 3, NarrowWidth = 4 instance
    b_valid_i = 1'b1; b_data_i = 12'hCBA; b_ready_i = 1'b1;
    step();
    b_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("r3_valid", b_valid_o, 1'b1);
      chk("r3_data", b_data_o, lane_b(12'hCBA, i));
      chk("r3_last", b_last_o, i == 2);
      step();
    end
    chk("r3_done_valid", b_valid_o, 1'b0);
    chk("r3_done_idle", b_idle_o, 1'b1);
    b_valid_i = 1'b1; b_data_i = 12'h321;
    step();
    b_valid_i = 1'b0;
    chk("r3_restart", b_data_o, lane_b(12'h321, 0));
    for (int i = 0; i < 3; i++) step();

    // Random traffic with backpressure and occasional flush
    for (int c = 0; c < 400; c++) begin
      valid_i = $urandom_range(0, 1);
      data_i  = $urandom;
      ready_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 31) == 0);
      step();
    end
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    for (int c = 0; c < R + 1; c++) step();
    chk("rnd_drained", idle_o, 1'b1);

    // Asynchronous reset in the middle of beat 2
    w = 32'h87654321;
    valid_i = 1'b1; data_i = w;
    step();
    valid_i = 1'b0;
    step();
    step();
    chk("ar_beat2", data_o, lane_of(w, 2));
    #2; rst_n = 1'b0;
    #1;
    chk("ar_valid", valid_o, 1'b0);
    chk("ar_ready", ready_o, 1'b1);
    chk("ar_idle", idle_o, 1'b1);
    chk("ar_data", data_o, 8'h00);
    q.delete();
    #2; rst_n = 1'b1;
    @(posedge clk); #1;
    w = 32'hA5C30F96;
    valid_i = 1'b1; data_i = w;
    step();
    valid_i = 1'b0;
    for (int i = 0; i < R; i++) begin
      chk("ar_fresh", data_o, lane_of(w, i));
      step();
    end
    chk("ar_end_idle", idle_o, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
